// File: rtl/input_conditioner_pkg.sv
// Shared types and defaults for the SLC-3 front-panel input conditioner.
// Button channels and the top-level pulse/reset logic both import this package.
package slc3_io_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } debounce_state_t;

    // While qualifying a release the button is still reported as held.
    function automatic logic state_is_held(debounce_state_t s);
        return (s == PRESSED) || (s == RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Signal bundles for the input conditioner: one per button channel, and one
// grouping the whole block's raw inputs and conditioned outputs.

// Handshake-free level bundle: raw active-low button in, debounced level and
// FSM state out.
interface debounce_if;
    import slc3_io_pkg::*;

    logic            btn_n;
    logic            held;
    debounce_state_t state;

    modport master (output btn_n, input held, input state);
    modport slave  (input btn_n, output held, output state);
endinterface

interface input_conditioner_if;
    logic       run_n;
    logic       continue_n;
    logic [9:0] sw_raw;
    logic [9:0] sw_sync;
    logic       run_held;
    logic       continue_held;
    logic       run_pulse;
    logic       continue_pulse;
    logic       cpu_reset;

    modport master (
        output run_n, continue_n, sw_raw,
        input  sw_sync, run_held, continue_held, run_pulse, continue_pulse, cpu_reset
    );
    modport slave (
        input  run_n, continue_n, sw_raw,
        output sw_sync, run_held, continue_held, run_pulse, continue_pulse, cpu_reset
    );
endinterface

// File: rtl/input_conditioner_debounce_channel.sv
// One push-button channel: 2-flop synchronizer, then a four-state debounce FSM
// that accepts a level only after DEBOUNCE_CYCLES consecutive stable samples.
module debounce_channel
    import slc3_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic      clk_i,
    input  logic      rst_i,
    debounce_if.slave bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam bit SINGLE_CYCLE = (DEBOUNCE_CYCLES == 1);
    // The cycle that enters a *_WAIT state already counts as the first stable
    // sample, so the wait state finishes when the counter reaches D-2.
    localparam logic [CNT_W-1:0] LAST_CNT =
        (DEBOUNCE_CYCLES >= 2) ? CNT_W'(DEBOUNCE_CYCLES - 2) : '0;

    logic            sync1_q;
    logic            sync2_q;
    debounce_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Synchronizer resets to the released (high) level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus.btn_n;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RELEASED: begin
                if (!sync2_q) begin
                    state_d = SINGLE_CYCLE ? PRESSED : PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (sync2_q) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (sync2_q) begin
                    state_d = SINGLE_CYCLE ? RELEASED : RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!sync2_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.held  = state_is_held(state_q);
    assign bus.state = state_q;

endmodule

// File: rtl/input_conditioner.sv
// SLC-3 front-panel conditioner: synchronizes switches, debounces Run and
// Continue, and derives single-cycle press strobes and the CPU reset request.
module input_conditioner
    import slc3_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Run_n,
    input  logic            Continue_n,
    input  logic [9:0]      SW_raw,
    output logic [9:0]      SW_sync,
    output logic            run_held,
    output logic            continue_held,
    output logic            run_pulse,
    output logic            continue_pulse,
    output logic            cpu_reset,
    output debounce_state_t run_state_dbg_o,
    output debounce_state_t continue_state_dbg_o
);

    logic [9:0] sw_sync1_q;
    logic [9:0] sw_sync2_q;
    logic       run_held_prev_q;
    logic       continue_held_prev_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
        end else begin
            sw_sync1_q <= SW_raw;
            sw_sync2_q <= sw_sync1_q;
        end
    end

    assign SW_sync = sw_sync2_q;

    debounce_if run_bus ();
    debounce_if continue_bus ();

    assign run_bus.btn_n      = Run_n;
    assign continue_bus.btn_n = Continue_n;

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_run (
        .clk_i(Clk),
        .rst_i(Reset),
        .bus  (run_bus)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_continue (
        .clk_i(Clk),
        .rst_i(Reset),
        .bus  (continue_bus)
    );

    assign run_held             = run_bus.held;
    assign continue_held        = continue_bus.held;
    assign run_state_dbg_o      = run_bus.state;
    assign continue_state_dbg_o = continue_bus.state;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            run_held_prev_q      <= 1'b0;
            continue_held_prev_q <= 1'b0;
        end else begin
            run_held_prev_q      <= run_held;
            continue_held_prev_q <= continue_held;
        end
    end

    // A press strobes only when the other button is idle, so the two-button
    // reset chord (or a tie) never leaks a Run/Continue command.
    assign run_pulse      = run_held & ~run_held_prev_q & ~continue_held;
    assign continue_pulse = continue_held & ~continue_held_prev_q & ~run_held;
    assign cpu_reset      = run_held & continue_held;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed front-panel scenarios followed by
// random button/switch activity, all checked against a sample-history model.
module tb_input_conditioner;
    import slc3_io_pkg::*;

    localparam int D = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    input_conditioner_if ic ();
    debounce_state_t run_state;
    debounce_state_t cont_state;

    input_conditioner #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .Clk                 (clk),
        .Reset               (reset),
        .Run_n               (ic.run_n),
        .Continue_n          (ic.continue_n),
        .SW_raw              (ic.sw_raw),
        .SW_sync             (ic.sw_sync),
        .run_held            (ic.run_held),
        .continue_held       (ic.continue_held),
        .run_pulse           (ic.run_pulse),
        .continue_pulse      (ic.continue_pulse),
        .cpu_reset           (ic.cpu_reset),
        .run_state_dbg_o     (run_state),
        .continue_state_dbg_o(cont_state)
    );

    // ---------------- scoreboard ----------------
    int passed = 0;
    int total  = 0;
    logic [14:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    // Buttons: the debouncer sees each raw sample two edges late; a level is
    // accepted once it has differed from the held level for D edges in a row.
    bit         run_smp[$];
    bit         cont_smp[$];
    logic [9:0] sw_smp[$];
    bit         m_held[2];
    int         m_len[2];

    task automatic model_edge();
        bit         obs[2];
        bit         prev[2];
        bit         pulse[2];
        logic [9:0] exp_sw;
        pulse[0] = 1'b0;
        pulse[1] = 1'b0;
        if (reset) begin
            sw_smp.delete();
            sw_smp.push_back(10'd0);
            run_smp.delete();
            run_smp.push_back(1'b1);
            run_smp.push_back(1'b1);
            cont_smp.delete();
            cont_smp.push_back(1'b1);
            cont_smp.push_back(1'b1);
            exp_sw = 10'd0;
            for (int ch = 0; ch < 2; ch++) begin
                m_held[ch] = 1'b0;
                m_len[ch]  = 0;
            end
        end else begin
            exp_sw = sw_smp[$];
            sw_smp.push_back(ic.sw_raw);
            obs[0] = run_smp[$-1];
            obs[1] = cont_smp[$-1];
            run_smp.push_back(ic.run_n);
            cont_smp.push_back(ic.continue_n);
            for (int ch = 0; ch < 2; ch++) begin
                prev[ch] = m_held[ch];
                if ((!obs[ch]) != m_held[ch]) begin
                    m_len[ch]++;
                    if (m_len[ch] == D) begin
                        m_held[ch] = !m_held[ch];
                        m_len[ch]  = 0;
                    end
                end else begin
                    m_len[ch] = 0;
                end
            end
            pulse[0] = m_held[0] && !prev[0] && !m_held[1];
            pulse[1] = m_held[1] && !prev[1] && !m_held[0];
        end
        while (sw_smp.size() > 4) void'(sw_smp.pop_front());
        while (run_smp.size() > 4) void'(run_smp.pop_front());
        while (cont_smp.size() > 4) void'(cont_smp.pop_front());
        exp_q.push_back({exp_sw, m_held[0], m_held[1], pulse[0], pulse[1],
                         m_held[0] & m_held[1]});
    endtask

    task automatic compare();
        logic [14:0] e;
        e = exp_q.pop_front();
        check("sw_sync",        32'(ic.sw_sync),        32'(e[14:5]));
        check("run_held",       32'(ic.run_held),       32'(e[4]));
        check("continue_held",  32'(ic.continue_held),  32'(e[3]));
        check("run_pulse",      32'(ic.run_pulse),      32'(e[2]));
        check("continue_pulse", 32'(ic.continue_pulse), 32'(e[1]));
        check("cpu_reset",      32'(ic.cpu_reset),      32'(e[0]));
    endtask

    // ---------------- driver ----------------
    // Inputs change 1 ns after an edge; every step checks the whole output set.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_buttons(input bit run_n, input bit cont_n);
        ic.run_n      = run_n;
        ic.continue_n = cont_n;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int run_cnt;
        int cont_cnt;
        reset     = 1'b1;
        ic.sw_raw = 10'h3FF;
        set_buttons(1'b1, 1'b1);

        // reset behaviour and switch synchronizer latency
        steps(2);
        check("rst_sw_sync", 32'(ic.sw_sync), 32'h0);
        check("rst_run_state", 32'(run_state), 32'(RELEASED));
        reset = 1'b0;
        step();
        check("post_rst_sw_sync", 32'(ic.sw_sync), 32'h0);
        step();
        check("sw_sync_latency", 32'(ic.sw_sync), 32'h3FF);

        // clean Run press
        set_buttons(1'b0, 1'b1);
        steps(5);
        check("run_t5_held", 32'(ic.run_held), 32'h0);
        step();
        check("run_t6_held", 32'(ic.run_held), 32'h1);
        check("run_t6_pulse", 32'(ic.run_pulse), 32'h1);
        check("run_t6_state", 32'(run_state), 32'(PRESSED));
        step();
        check("run_t7_pulse", 32'(ic.run_pulse), 32'h0);
        check("run_t7_cont", 32'(ic.continue_held), 32'h0);
        steps(3);
        set_buttons(1'b1, 1'b1);
        steps(8);
        check("run_released", 32'(ic.run_held), 32'h0);

        // bounce: low 3, high 1, then steady low
        set_buttons(1'b0, 1'b1);
        steps(3);
        set_buttons(1'b1, 1'b1);
        step();
        set_buttons(1'b0, 1'b1);
        steps(5);
        check("bounce_t5_held", 32'(ic.run_held), 32'h0);
        step();
        check("bounce_t6_pulse", 32'(ic.run_pulse), 32'h1);
        set_buttons(1'b1, 1'b1);
        steps(8);

        // both buttons together: reset chord, no pulses
        set_buttons(1'b0, 1'b0);
        steps(6);
        check("chord_cpu_reset", 32'(ic.cpu_reset), 32'h1);
        check("chord_run_pulse", 32'(ic.run_pulse), 32'h0);
        check("chord_cont_pulse", 32'(ic.continue_pulse), 32'h0);
        set_buttons(1'b1, 1'b0);
        steps(5);
        check("chord_u5_cpu_reset", 32'(ic.cpu_reset), 32'h1);
        step();
        check("chord_u6_cpu_reset", 32'(ic.cpu_reset), 32'h0);
        set_buttons(1'b1, 1'b1);
        steps(8);

        // Continue held first, Run pressed later
        set_buttons(1'b1, 1'b0);
        steps(10);
        set_buttons(1'b0, 1'b0);
        steps(6);
        check("late_run_cpu_reset", 32'(ic.cpu_reset), 32'h1);
        check("late_run_pulse", 32'(ic.run_pulse), 32'h0);
        set_buttons(1'b1, 1'b1);
        steps(8);

        // Reset in the middle of a press qualification
        set_buttons(1'b0, 1'b1);
        steps(5);
        reset = 1'b1;
        steps(3);
        check("midrst_held", 32'(ic.run_held), 32'h0);
        reset = 1'b0;
        steps(5);
        check("midrst_t5_pulse", 32'(ic.run_pulse), 32'h0);
        step();
        check("midrst_t6_pulse", 32'(ic.run_pulse), 32'h1);
        set_buttons(1'b1, 1'b1);
        steps(8);

        // random button levels with random dwell, random switches, rare resets
        run_cnt  = 0;
        cont_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            if (run_cnt == 0) begin
                ic.run_n = 1'($urandom_range(0, 1));
                run_cnt  = $urandom_range(1, 12);
            end
            if (cont_cnt == 0) begin
                ic.continue_n = 1'($urandom_range(0, 1));
                cont_cnt      = $urandom_range(1, 12);
            end
            run_cnt--;
            cont_cnt--;
            ic.sw_raw = 10'($urandom_range(0, 1023));
            reset     = ($urandom_range(0, 59) == 0);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter: DEBOUNCE_CYCLES, default 4, consecutive stable synchronized cycles required to accept a level change; legal range >= 1.
REQ-002 SHALL have port: Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: Run_n  input  1  raw asynchronous Run push-button, active-low (0 = pressed).
REQ-005 SHALL have port: Continue_n  input  1  raw asynchronous Continue push-button, active-low.
REQ-006 SHALL have port: SW_raw  input  10  raw asynchronous slide switches.
REQ-007 SHALL have port: SW_sync  output  10  switches after 2-flop synchronizer.
REQ-008 SHALL have port: run_held, continue_held  output  1 each  debounced level, active-high (1 = pressed).
REQ-009 SHALL have port: run_pulse, continue_pulse  output  1 each  single-cycle strobe on accepted press.
REQ-010 SHALL have port: cpu_reset  output  1  high while both buttons are debounced-held; drives the SLC-3 reset.

Function
REQ-011 Each of Run_n, Continue_n, SW_raw[9:0] SHALL pass through two flops (sync1, sync2) before any use; SW_sync = sync2 of SW_raw, latency 2 edges.
REQ-012 Each button channel SHALL run FSM RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-013 RELEASED: sync2 = 0 (pressed) -> PRESS_WAIT, counter cleared to 0.
REQ-014 PRESS_WAIT: sync2 = 0 increments counter; counter reaching DEBOUNCE_CYCLES-1 with sync2 = 0 -> PRESSED; sync2 = 1 at any point -> RELEASED, counter 0.
REQ-015 PRESSED / RELEASE_WAIT SHALL mirror REQ-013/014 with opposite polarity.
REQ-016 *_held SHALL be 1 in PRESSED and RELEASE_WAIT, else 0; held changes at the (2+DEBOUNCE_CYCLES)th edge after a clean raw transition.
REQ-017 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1); counter never wraps (cleared on every state change).
REQ-018 *_pulse SHALL be 1 for exactly the one cycle in which that channel's held goes 0->1, and only if the other channel's held is 0 in that cycle.
REQ-019 Simultaneous acceptance (both held rise same cycle) SHALL produce no pulse on either channel.
REQ-020 cpu_reset SHALL equal run_held AND continue_held (combinational from registered state), no pulses while asserted.
REQ-021 Release SHALL never generate a pulse; a held button SHALL not re-pulse.

Reset
REQ-022 Reset SHALL set: button sync flops to 1 (released), SW sync flops to 0, FSMs to RELEASED, counters to 0.
REQ-023 During and first cycle after Reset: SW_sync = 0, *_held = 0, *_pulse = 0, cpu_reset = 0.
REQ-024 Reset mid-debounce SHALL abort the debounce; no pulse SHALL emerge from a press begun before Reset deasserts unless re-qualified for full latency afterwards.

Structure
REQ-025 Package slc3_io_pkg SHALL hold debounce_state_t enum and DEFAULT_DEBOUNCE_CYCLES constant.
REQ-026 One sub-module debounce_channel (sync + FSM + counter, one button) SHALL be instantiated twice; pulse qualification and cpu_reset live in top.

Verification (DEBOUNCE_CYCLES = 4)
REQ-027 Reset 2 cycles, buttons released, SW_raw = 0x3FF -> all outputs 0 during reset; SW_sync = 0x3FF 2 edges after release.
REQ-028 Run_n falls cleanly at edge t -> run_held = 1 and run_pulse = 1 at t+6, run_pulse = 0 at t+7; continue_* stay 0.
REQ-029 Run_n low 3 cycles, high 1, then low steady -> no pulse during bounce; run_held and single pulse at 6 edges after final fall.
REQ-030 Run_n and Continue_n fall same edge t -> cpu_reset = 1 at t+6, no pulses; Run_n released at u -> cpu_reset = 0 at u+6.
REQ-031 Continue_n held, Run_n falls later -> cpu_reset asserts, run_pulse stays 0.
REQ-032 Reset asserted 3 cycles into PRESS_WAIT -> held/pulse remain 0; button still pressed after Reset -> pulse 6 edges after Reset deasserts.
